// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Optional build macro used by the arbiter: MEMARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int MEMARB_OUTSTANDING_DEFAULT = 4;
    localparam int MEMARB_ADDR_W = 32;
    localparam int MEMARB_DATA_W = 32;

    // Which client issued an outstanding read.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // One request as presented to the memory.
    typedef struct packed {
        logic                     we;
        logic [MEMARB_ADDR_W-1:0] addr;
        logic [MEMARB_DATA_W-1:0] data;
    } mem_req_t;

    // The client that did not win last time.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of 1-bit read owners; push and pop may
// coincide, including a push while full when a pop frees the slot.
module tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MEMARB_OUTSTANDING_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_e din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    owner_e          mem_q [DEPTH];
    owner_e          mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = mem_q[rd_q];

    // Next pointers, storage and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: OWN_FETCH};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (client 0) and data (client 1).
// MEMARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = MEMARB_ADDR_W,
    parameter int DATA_W      = MEMARB_DATA_W,
    parameter int OUTSTANDING = MEMARB_OUTSTANDING_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              c0_req_ena,
    input  logic [ADDR_W-1:0] c0_req_addr,
    output logic              c0_req_rdy,
    input  logic              c1_req_ena,
    input  logic              c1_req_we,
    input  logic [ADDR_W-1:0] c1_req_addr,
    input  logic [DATA_W-1:0] c1_req_data,
    output logic              c1_req_rdy,
    output logic              c0_rsp_ena,
    input  logic              c0_rsp_rdy,
    output logic              c1_rsp_ena,
    input  logic              c1_rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              m_req_ena,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_data,
    input  logic              m_req_rdy,
    input  logic              m_rsp_ena,
    input  logic [DATA_W-1:0] m_rsp_data,
    output logic              m_rsp_rdy
);

    logic     fifo_full;
    logic     fifo_empty;
    owner_e   head;
    logic     push;
    logic     pop;
    logic     slot_ok;
    logic     c0_elig;
    logic     c1_elig;
    logic     win_vld;
    owner_e   win;
    mem_req_t req;

`ifdef MEMARB_ROUND_ROBIN_EN
    owner_e   last_q, last_d;
`endif

    // Route the in-order memory response to the head owner.
    always_comb begin
        c0_rsp_ena = m_rsp_ena && !fifo_empty && (head == OWN_FETCH);
        c1_rsp_ena = m_rsp_ena && !fifo_empty && (head == OWN_DATA);
        rsp_data   = m_rsp_data;
        if (fifo_empty) begin
            m_rsp_rdy = 1'b1;
        end else if (head == OWN_DATA) begin
            m_rsp_rdy = c1_rsp_rdy;
        end else begin
            m_rsp_rdy = c0_rsp_rdy;
        end
        pop = m_rsp_ena && m_rsp_rdy && !fifo_empty;
    end

    // Pick at most one eligible client and mux its request.
    always_comb begin
        slot_ok = !fifo_full || pop;
        c0_elig = c0_req_ena && slot_ok;
        c1_elig = c1_req_ena && (c1_req_we || slot_ok);
        win_vld = c0_elig || c1_elig;
        win     = OWN_DATA;
        if (c0_elig && c1_elig) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            win = other_owner(last_q);
`else
            win = OWN_DATA;
`endif
        end else if (c0_elig) begin
            win = OWN_FETCH;
        end
        req = '0;
        if (win_vld) begin
            if (win == OWN_DATA) begin
                req.we   = c1_req_we;
                req.addr = c1_req_addr;
                req.data = c1_req_data;
            end else begin
                req.we   = 1'b0;
                req.addr = c0_req_addr;
                req.data = '0;
            end
        end
        m_req_ena  = win_vld;
        m_req_we   = req.we;
        m_req_addr = req.addr;
        m_req_data = req.data;
        c0_req_rdy = win_vld && (win == OWN_FETCH) && m_req_rdy;
        c1_req_rdy = win_vld && (win == OWN_DATA) && m_req_rdy;
        push       = win_vld && m_req_rdy && !req.we;
    end

    tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tags (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .din   (win),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

`ifdef MEMARB_ROUND_ROBIN_EN
    // Remember the last accepted client.
    always_comb begin
        last_d = last_q;
        if (win_vld && m_req_rdy) begin
            last_d = win;
        end
    end

    // Last-grant pointer; reset value lets data win first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= OWN_FETCH;
        end else begin
            last_q <= last_d;
        end
    end
`endif

`ifndef SYNTHESIS
    logic [3:0] since_rst_q, since_rst_d;

    // Saturating count of cycles since reset.
    always_comb begin
        since_rst_d = since_rst_q;
        if (since_rst_q != 4'd8) begin
            since_rst_d = since_rst_q + 4'd1;
        end
    end

    // Settle-window counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            since_rst_q <= '0;
        end else begin
            since_rst_q <= since_rst_d;
        end
    end

    // A response with nothing outstanding is a memory protocol error.
    always_ff @(posedge CLK) begin
        if (!RST && since_rst_q == 4'd8) begin
            assert (!(m_rsp_ena && fifo_empty))
                else $error("memory response with no outstanding read");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter.
// Honours MEMARB_ROUND_ROBIN_EN for the conflict sequence.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        c0_req_ena;
    logic [31:0] c0_req_addr;
    logic        c0_req_rdy;
    logic        c1_req_ena;
    logic        c1_req_we;
    logic [31:0] c1_req_addr;
    logic [31:0] c1_req_data;
    logic        c1_req_rdy;
    logic        c0_rsp_ena;
    logic        c0_rsp_rdy;
    logic        c1_rsp_ena;
    logic        c1_rsp_rdy;
    logic [31:0] rsp_data;
    logic        m_req_ena;
    logic        m_req_we;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_data;
    logic        m_req_rdy;
    logic        m_rsp_ena;
    logic [31:0] m_rsp_data;
    logic        m_rsp_rdy;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        c0e;
        logic [31:0] c0a;
        logic        c1e;
        logic        c1we;
        logic [31:0] c1a;
        logic [31:0] c1d;
        logic        c0rr;
        logic        c1rr;
        logic        mrr;
        logic        mre;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        c0q;
        logic        c1q;
        logic        c0r;
        logic        c1r;
        logic        me;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] md;
        logic        mrr;
        logic [31:0] rd;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    mem_port_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .c0_req_ena  (c0_req_ena),
        .c0_req_addr (c0_req_addr),
        .c0_req_rdy  (c0_req_rdy),
        .c1_req_ena  (c1_req_ena),
        .c1_req_we   (c1_req_we),
        .c1_req_addr (c1_req_addr),
        .c1_req_data (c1_req_data),
        .c1_req_rdy  (c1_req_rdy),
        .c0_rsp_ena  (c0_rsp_ena),
        .c0_rsp_rdy  (c0_rsp_rdy),
        .c1_rsp_ena  (c1_rsp_ena),
        .c1_rsp_rdy  (c1_rsp_rdy),
        .rsp_data    (rsp_data),
        .m_req_ena   (m_req_ena),
        .m_req_we    (m_req_we),
        .m_req_addr  (m_req_addr),
        .m_req_data  (m_req_data),
        .m_req_rdy   (m_req_rdy),
        .m_rsp_ena   (m_rsp_ena),
        .m_rsp_data  (m_rsp_data),
        .m_rsp_rdy   (m_rsp_rdy)
    );

    always #5 CLK = ~CLK;

    function automatic in_t mi(
        input logic c0e, input logic [31:0] c0a,
        input logic c1e, input logic c1we,
        input logic [31:0] c1a, input logic [31:0] c1d,
        input logic c0rr, input logic c1rr, input logic mrr,
        input logic mre, input logic [31:0] mrd);
        in_t v;
        v = '{c0e, c0a, c1e, c1we, c1a, c1d, c0rr, c1rr, mrr, mre, mrd};
        return v;
    endfunction

    function automatic out_t mo(
        input logic c0q, input logic c1q,
        input logic c0r, input logic c1r,
        input logic me, input logic mwe,
        input logic [31:0] ma, input logic [31:0] md,
        input logic mrr, input logic [31:0] rd);
        out_t v;
        v = '{c0q, c1q, c0r, c1r, me, mwe, ma, md, mrr, rd};
        return v;
    endfunction

    function automatic void add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endfunction

    task automatic drive(input in_t v);
        c0_req_ena  = v.c0e;
        c0_req_addr = v.c0a;
        c1_req_ena  = v.c1e;
        c1_req_we   = v.c1we;
        c1_req_addr = v.c1a;
        c1_req_data = v.c1d;
        c0_rsp_rdy  = v.c0rr;
        c1_rsp_rdy  = v.c1rr;
        m_req_rdy   = v.mrr;
        m_rsp_ena   = v.mre;
        m_rsp_data  = v.mrd;
    endtask

    task automatic chk(input string name, input out_t exp);
        out_t act;
        act = '{c0_req_rdy, c1_req_rdy, c0_rsp_ena, c1_rsp_ena,
                m_req_ena, m_req_we, m_req_addr, m_req_data,
                m_rsp_rdy, rsp_data};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input logic [1:0] got,
                        input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    function automatic in_t idle();
        return mi(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    endfunction

    function automatic in_t rd0(input logic [31:0] a);
        return mi(1, a, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    endfunction

    function automatic in_t rsp(input logic [31:0] d);
        return mi(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, d);
    endfunction

    function automatic out_t g0(input logic [31:0] a);
        return mo(1, 0, 0, 0, 1, 0, a, 0, 1, 0);
    endfunction

    function automatic out_t r0(input logic [31:0] d);
        return mo(0, 0, 1, 0, 0, 0, 0, 0, 1, d);
    endfunction

    initial begin
        logic [1:0] rr_exp [3];
        out_t quiet;
        quiet = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // reset state and single fetch
        add(idle(), quiet);
        add(rd0(32'h100), g0(32'h100));
        add(rsp(32'hDEADBEEF), r0(32'hDEADBEEF));
        // conflict: data write wins, fetch next cycle
        add(mi(1, 32'h10, 1, 1, 32'h20, 32'h55, 1, 1, 1, 0, 0),
            mo(0, 1, 0, 0, 1, 1, 32'h20, 32'h55, 1, 0));
        add(rd0(32'h10), g0(32'h10));
        add(rsp(32'h1234), r0(32'h1234));
        // interleaved reads and in-order routing
        add(rd0(32'h200), g0(32'h200));
        add(mi(0, 0, 1, 0, 32'h300, 32'hAA, 1, 1, 1, 0, 0),
            mo(0, 1, 0, 0, 1, 0, 32'h300, 32'hAA, 1, 0));
        add(rd0(32'h204), g0(32'h204));
        add(rsp(32'hA), r0(32'hA));
        add(rsp(32'hB), mo(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'hB));
        add(rsp(32'hC), r0(32'hC));
        // data client stalls its response for three cycles
        add(mi(0, 0, 1, 0, 32'h400, 0, 1, 1, 1, 0, 0),
            mo(0, 1, 0, 0, 1, 0, 32'h400, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            add(mi(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h77),
                mo(0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h77));
        end
        add(rsp(32'h77), mo(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h77));
        add(idle(), quiet);
        // memory not ready: request shown, not accepted
        add(mi(1, 32'h444, 0, 0, 0, 0, 1, 1, 0, 0, 0),
            mo(0, 0, 0, 0, 1, 0, 32'h444, 0, 1, 0));
        // fill the tag FIFO
        for (int k = 0; k < 4; k++) begin
            add(rd0(32'h500 + 32'(4 * k)), g0(32'h500 + 32'(4 * k)));
        end
        add(rd0(32'h510), quiet);
        add(mi(1, 32'h510, 1, 1, 32'h600, 32'h66, 1, 1, 1, 0, 0),
            mo(0, 1, 0, 0, 1, 1, 32'h600, 32'h66, 1, 0));
        add(mi(1, 32'h510, 0, 0, 0, 0, 1, 1, 1, 1, 32'hF0),
            mo(1, 0, 1, 0, 1, 0, 32'h510, 0, 1, 32'hF0));
        for (int k = 1; k <= 4; k++) begin
            add(rsp(32'hF0 + 32'(k)), r0(32'hF0 + 32'(k)));
        end
        // two reads left outstanding for the reset case
        add(rd0(32'h700), g0(32'h700));
        add(rd0(32'h704), g0(32'h704));

        drive(idle());
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        foreach (tbl[n]) begin
            drive(tbl[n].i);
            #2;
            chk($sformatf("vec%0d", n), tbl[n].o);
            @(posedge CLK);
            #1;
        end

        // reset with reads outstanding
        drive(idle());
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        chk("rst_idle", quiet);
        @(posedge CLK);
        #1;
        drive(rsp(32'h99));
        #2;
        chk("rst_stray", mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
        @(posedge CLK);
        #1;

        // persistent conflict: {c0_req_rdy, c1_req_rdy} per cycle
`ifdef MEMARB_ROUND_ROBIN_EN
        rr_exp = '{2'b01, 2'b10, 2'b01};
`else
        rr_exp = '{2'b01, 2'b01, 2'b01};
`endif
        drive(mi(1, 32'h800, 1, 1, 32'h900, 32'h1, 1, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            #2;
            chk2($sformatf("conflict%0d", k),
                 {c0_req_rdy, c1_req_rdy}, rr_exp[k]);
            @(posedge CLK);
            #1;
        end
        drive(idle());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
